// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: enumerates every WIDTH-bit word with exactly k ones, in
// increasing numeric order, one word per accepted valid/ready transfer.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start, k     request a new enumeration of words with k ones (IDLE only)
//   busy         high from the cycle after an accepted start until DONE completes
//   out_valid    pattern holds a word
//   out_ready    consumer accepts the word
//   pattern      current word
//   last         pattern is the final word of the enumeration
//   pat_cnt      words accepted so far in this enumeration
//   done         one-cycle pulse after the final word is accepted
//   err          one-cycle pulse when start arrives with k > WIDTH
module ones_pattern_gen #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CW    = 5,
   parameter int unsigned NW    = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CW-1:0]    k,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] pattern,
   output logic             last,
   output logic [NW-1:0]    pat_cnt,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

   localparam logic [CW-1:0] WidthCw = CW'(WIDTH);
   localparam logic [WIDTH:0] OneW   = {{WIDTH{1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [CW-1:0]      k_q, k_d;
   logic [WIDTH-1:0]   pattern_q, pattern_d;
   logic               last_q, last_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic [NW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               start_ok, start_bad, xfer;
   logic [CW-1:0]      tz;
   logic [WIDTH-1:0]   lsb, nxt, top_k;
   logic [WIDTH:0]     sum;
   logic               carry_unused;

   // Word with the n lowest bits set; one extra bit so n == WIDTH works.
   function automatic logic [WIDTH-1:0] low_ones(input logic [CW-1:0] n);
      return WIDTH'((OneW << n) - OneW);
   endfunction

   assign start_ok  = start & (k <= WidthCw);
   assign start_bad = start & (k > WidthCw);
   assign xfer      = valid_q & out_ready;

   // Trailing-zero count; scanning downwards lets the lowest set bit win.
   always_comb begin
      tz = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pattern_q[i]) tz = CW'(i);
      end
   end

   // Gosper step: the shift by tz replaces the division by the lowest set bit.
   // The carry-out only occurs past the final word, which is never advanced.
   always_comb begin
      lsb          = pattern_q & (~pattern_q + 1'b1);
      sum          = {1'b0, pattern_q} + {1'b0, lsb};
      carry_unused = sum[WIDTH];
      nxt          = sum[WIDTH-1:0] | (((sum[WIDTH-1:0] ^ pattern_q) >> 2) >> tz);
      top_k        = low_ones(k_q) << (WidthCw - k_q);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_ok) state_d = StEmit;
         StEmit:  if (xfer && last_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      k_d       = k_q;
      pattern_d = pattern_q;
      last_d    = last_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               k_d       = k;
               pattern_d = low_ones(k);
               last_d    = (k == '0) || (k == WidthCw);
               valid_d   = 1'b1;
               busy_d    = 1'b1;
               cnt_d     = '0;
            end else if (start_bad) begin
               err_d = 1'b1;
            end
         end
         StEmit: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pattern_d = nxt;
                  last_d    = (nxt == top_k);
               end
            end
         end
         StDone: begin
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q       <= '0;
         pattern_q <= '0;
         last_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         k_q       <= k_d;
         pattern_q <= pattern_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign pattern   = pattern_q;
   assign last      = last_q;
   assign pat_cnt   = cnt_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;

   localparam int WIDTH = 16;
   localparam int CW    = 5;
   localparam int NW    = 14;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CW-1:0]    k = '0;
   logic             out_ready = 1'b0;
   logic             busy, out_valid, last, done, err;
   logic [WIDTH-1:0] pattern;
   logic [NW-1:0]    pat_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .NW(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k         (k),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pattern   (pattern),
      .last      (last),
      .pat_cnt   (pat_cnt),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference: smallest word above x with exactly kk ones (brute-force scan).
   function automatic int next_word(input int x, input int kk);
      for (int v = x + 1; v < (1 << WIDTH); v++) begin
         if ($countones(v) == kk) return v;
      end
      return -1;
   endfunction

   function automatic int choose(input int n, input int r);
      longint acc = 1;
      for (int i = 0; i < r; i++) acc = acc * (n - i) / (i + 1);
      return int'(acc);
   endfunction

   // Full enumeration of kk with random ready; optionally pokes start mid-run.
   task automatic run_enum(input int kk, input int ready_pct, input bit poke);
      int total, idx, exp_pat, cycles;
      bit stalled, fin;
      logic [WIDTH-1:0] held;
      total   = choose(WIDTH, kk);
      exp_pat = next_word(-1, kk);
      @(negedge clk);
      start = 1'b1;
      k     = CW'(kk);
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1)
         $display("FAIL start_latency k=%0d: busy=%b valid=%b expected 1/1", kk, busy, out_valid);
      else n_pass++;
      idx = 0; fin = 0; cycles = 0; stalled = 0; held = '0;
      while (!fin && cycles < total * 4 + 50) begin
         cycles++;
         n_checks++;
         if (out_valid !== 1'b1)
            $display("FAIL valid_hold k=%0d idx=%0d: valid=%b expected 1", kk, idx, out_valid);
         else n_pass++;
         n_checks++;
         if (pattern !== WIDTH'(exp_pat))
            $display("FAIL pattern k=%0d idx=%0d: got %h expected %h", kk, idx, pattern,
                     WIDTH'(exp_pat));
         else n_pass++;
         n_checks++;
         if ($countones(pattern) != kk)
            $display("FAIL popcount k=%0d idx=%0d: got %0d expected %0d", kk, idx,
                     $countones(pattern), kk);
         else n_pass++;
         n_checks++;
         if (last !== (idx == total - 1))
            $display("FAIL last k=%0d idx=%0d: got %b expected %b", kk, idx, last,
                     (idx == total - 1));
         else n_pass++;
         n_checks++;
         if (pat_cnt !== NW'(idx))
            $display("FAIL pat_cnt k=%0d: got %0d expected %0d", kk, pat_cnt, idx);
         else n_pass++;
         n_checks++;
         if (done !== 1'b0 || err !== 1'b0)
            $display("FAIL no_pulse k=%0d idx=%0d: done=%b err=%b expected 0/0", kk, idx, done,
                     err);
         else n_pass++;
         if (stalled) begin
            n_checks++;
            if (pattern !== held)
               $display("FAIL stall_stable k=%0d: got %h expected %h", kk, pattern, held);
            else n_pass++;
         end
         out_ready = ($urandom_range(99) < ready_pct);
         if (poke && idx == total / 2) begin
            start = 1'b1;
            k     = CW'($urandom_range(17));
         end else begin
            start = 1'b0;
         end
         held    = pattern;
         stalled = !out_ready;
         if (out_ready) begin
            idx++;
            if (idx == total) fin = 1;
            else exp_pat = next_word(exp_pat, kk);
         end
         @(negedge clk);
      end
      start     = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (!fin) $display("FAIL xfer_budget k=%0d: got %0d transfers expected %0d", kk, idx, total);
      else n_pass++;
      n_checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || last !== 1'b0)
         $display("FAIL done_pulse k=%0d: done=%b valid=%b busy=%b last=%b expected 1/0/1/0",
                  kk, done, out_valid, busy, last);
      else n_pass++;
      n_checks++;
      if (pat_cnt !== NW'(total))
         $display("FAIL final_cnt k=%0d: got %0d expected %0d", kk, pat_cnt, total);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pat_cnt !== NW'(total))
         $display("FAIL after_done k=%0d: done=%b busy=%b cnt=%0d expected 0/0/%0d", kk, done,
                  busy, pat_cnt, total);
      else n_pass++;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({busy, out_valid, pattern, last, pat_cnt, done, err} !== '0)
         $display("FAIL reset_values: got %h expected 0",
                  {busy, out_valid, pattern, last, pat_cnt, done, err});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, out_valid, done, err} !== '0)
         $display("FAIL idle_after_reset: got %b expected 0000", {busy, out_valid, done, err});
      else n_pass++;
   endtask

   task automatic test_k2();
      run_enum(2, 100, 1'b0);
   endtask

   task automatic test_single_and_edges();
      run_enum(1, 100, 1'b0);
      run_enum(0, 100, 1'b0);
      run_enum(16, 100, 1'b0);
   endtask

   task automatic test_k8_random_ready();
      run_enum(8, 60, 1'b0);
   endtask

   task automatic test_err();
      @(negedge clk);
      start = 1'b1;
      k     = CW'(17);
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
         $display("FAIL err_pulse: err=%b busy=%b valid=%b done=%b expected 1/0/0/0", err, busy,
                  out_valid, done);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL err_one_cycle: err=%b busy=%b valid=%b expected 0/0/0", err, busy,
                  out_valid);
      else n_pass++;
      run_enum(3, 100, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_enum(4, 70, 1'b1);
   endtask

   task automatic test_midreset();
      int exp_pat;
      @(negedge clk);
      start = 1'b1;
      k     = CW'(5);
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      out_ready = 1'b0;
      exp_pat   = next_word(-1, 5);
      for (int i = 0; i < 10; i++) exp_pat = next_word(exp_pat, 5);
      n_checks++;
      if (pat_cnt !== NW'(10) || pattern !== WIDTH'(exp_pat))
         $display("FAIL pre_reset: cnt=%0d pat=%h expected 10/%h", pat_cnt, pattern,
                  WIDTH'(exp_pat));
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, out_valid, pattern, last, pat_cnt, done, err} !== '0)
         $display("FAIL async_clear: got %h expected 0",
                  {busy, out_valid, pattern, last, pat_cnt, done, err});
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, out_valid, pattern, pat_cnt} !== '0)
         $display("FAIL stays_idle: got %h expected 0", {busy, out_valid, pattern, pat_cnt});
      else n_pass++;
      run_enum(5, 100, 1'b0);
   endtask

   initial begin
      test_reset();
      test_k2();
      test_single_and_edges();
      test_k8_random_ready();
      test_err();
      test_start_ignored();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
